// File: rtl/sprite_line_fetcher_pkg.sv
// Shared constants for the sprite line fetcher and the sprite ROM.
// No logic; orientation codes, sprite IDs and fetch FSM encoding.
// Not applicable (no handshake).
package sprite_line_fetcher_pkg;

    localparam int SPRITE_W = 8;

    // Orientation codes, shared with the sprite ROM
    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] RIGHT = 2'd1;
    localparam logic [1:0] DOWN  = 2'd2;
    localparam logic [1:0] LEFT  = 2'd3;

    // Sprite IDs stored in the ROM
    localparam logic [3:0] HEART          = 4'd0;
    localparam logic [3:0] SWORD          = 4'd1;
    localparam logic [3:0] GNOME_IDLE_1   = 4'd2;
    localparam logic [3:0] GNOME_IDLE_2   = 4'd3;
    localparam logic [3:0] DRAGON_WING_UP = 4'd4;
    localparam logic [3:0] DRAGON_WING_DN = 4'd5;
    localparam logic [3:0] DRAGON_HEAD    = 4'd6;
    localparam logic [3:0] SHEEP_IDLE_1   = 4'd7;
    localparam logic [3:0] SHEEP_IDLE_2   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sprite_line_fetcher_pixel_select.sv
// Per-slot hit test against hpos with fixed priority (slot 0 on top).
// Latency: 1 cycle, pixel_on/pixel_slot registered.
// No backpressure; evaluates every cycle.
module sprite_pixel_select
    import sprite_line_fetcher_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_display_on,
    input  logic [9:0]                     i_hpos,
    input  logic [10*NUM_SLOTS-1:0]        i_slot_x,
    input  logic [SPRITE_W*NUM_SLOTS-1:0]  i_line_buf,
    output logic                           o_pixel_on,
    output logic [SLOT_W-1:0]              o_pixel_slot
);

    logic              w_any;
    logic [SLOT_W-1:0] w_win;
    logic [10:0]       w_dx;
    logic [9:0]        w_x;

    // Find the lowest-index slot whose buffered pixel at hpos is lit.
    // Walk from the highest slot down so the lowest index overwrites last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_dx  = '0;
        w_x   = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            w_x  = i_slot_x[10*s +: 10];
            // 11-bit compare keeps slot_x+7 from wrapping near column 1023
            w_dx = {1'b0, i_hpos} - {1'b0, w_x};
            if ((i_hpos >= w_x) && (w_dx < 11'd8) &&
                (i_line_buf[SPRITE_W*s + int'(w_dx[2:0])] == 1'b0)) begin
                w_any = 1'b1;
                w_win = SLOT_W'(s);
            end
        end
    end

    // Register the winner; pixels only show in the active region.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_pixel_on   <= 1'b0;
            o_pixel_slot <= '0;
        end else begin
            o_pixel_on   <= i_display_on && w_any;
            o_pixel_slot <= w_win;
        end
    end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Fetches one ROM line per sprite slot during hblank, serialises them next line.
// Latency: NUM_SLOTS+1 cycles fetch from line_start; pixel path 1 cycle.
// No backpressure; ROM is combinational, line_start always restarts the fetch.
module sprite_line_fetcher
    import sprite_line_fetcher_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2,
    parameter int V_TOTAL   = 525
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    line_start,
    input  logic [9:0]              hpos,
    input  logic [9:0]              vpos,
    input  logic                    display_on,
    input  logic [NUM_SLOTS-1:0]    slot_valid,
    input  logic [10*NUM_SLOTS-1:0] slot_x,
    input  logic [10*NUM_SLOTS-1:0] slot_y,
    input  logic [4*NUM_SLOTS-1:0]  slot_id,
    input  logic [2*NUM_SLOTS-1:0]  slot_orient,
    output logic [3:0]              rom_sprite_id,
    output logic [2:0]              rom_line_index,
    output logic [1:0]              rom_orientation,
    input  logic [7:0]              rom_data,
    output logic                    pixel_on,
    output logic [SLOT_W-1:0]       pixel_slot,
    output logic                    fetch_busy
);

    fetch_state_t                  r_state;
    fetch_state_t                  w_state_nxt;
    logic [SLOT_W-1:0]             r_cnt;
    logic [9:0]                    r_next_line;
    logic [9:0]                    w_next_line;
    logic [SPRITE_W*NUM_SLOTS-1:0] r_buf;
    logic [10*NUM_SLOTS-1:0]       r_x;
    logic [9:0]                    w_sel_y;
    logic [10:0]                   w_dy;
    logic                          w_hit;
    logic                          w_last;

    assign w_next_line = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;

    // Slot currently addressed by the fetch counter; dy is 11 bits so a
    // sprite below the line yields a large value instead of wrapping small.
    assign w_sel_y = slot_y[10*int'(r_cnt) +: 10];
    assign w_dy    = {1'b0, r_next_line} - {1'b0, w_sel_y};
    assign w_hit   = slot_valid[r_cnt] && (r_next_line >= w_sel_y) && (w_dy < 11'd8);
    assign w_last  = (r_cnt == SLOT_W'(NUM_SLOTS - 1));

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and ROM request outputs (zero outside FETCH).
    always_comb begin
        w_state_nxt     = r_state;
        rom_sprite_id   = '0;
        rom_line_index  = '0;
        rom_orientation = '0;
        fetch_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (line_start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_busy      = 1'b1;
                rom_sprite_id   = slot_id[4*int'(r_cnt) +: 4];
                rom_orientation = slot_orient[2*int'(r_cnt) +: 2];
                rom_line_index  = w_dy[2:0];
                if (line_start)  w_state_nxt = ST_FETCH;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                fetch_busy = 1'b1;
                w_state_nxt = line_start ? ST_FETCH : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Slot counter and target line; any line_start restarts at slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_next_line <= '0;
        end else if (line_start) begin
            r_cnt       <= '0;
            r_next_line <= w_next_line;
        end else if (r_state == ST_FETCH) begin
            r_cnt <= r_cnt + SLOT_W'(1);
        end
    end

    // Capture ROM line (or blank on miss) and the slot's column while fetched,
    // so later slot changes only take effect on the next line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf <= '1;
            r_x   <= '0;
        end else if (r_state == ST_FETCH) begin
            r_buf[SPRITE_W*int'(r_cnt) +: SPRITE_W] <= w_hit ? rom_data : 8'hFF;
            r_x[10*int'(r_cnt) +: 10]               <= slot_x[10*int'(r_cnt) +: 10];
        end
    end

    sprite_pixel_select #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_pixel_select (
        .clk          (clk),
        .reset        (reset),
        .i_display_on (display_on),
        .i_hpos       (hpos),
        .i_slot_x     (r_x),
        .i_line_buf   (r_buf),
        .o_pixel_on   (pixel_on),
        .o_pixel_slot (pixel_slot)
    );

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Self-checking bench: behavioural ROM plus line/pixel reference model.
// Latency: checks fetch sequencing cycle by cycle and 1-cycle pixel path.
// No backpressure in the design under test.
module tb_sprite_line_fetcher;
    import sprite_line_fetcher_pkg::*;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int VT = 525;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, line_start, display_on;
    logic [9:0]      hpos, vpos;
    logic [N-1:0]    slot_valid;
    logic [9:0]      sx [N];
    logic [9:0]      sy [N];
    logic [3:0]      sid[N];
    logic [1:0]      sor[N];
    logic [10*N-1:0] slot_x_bus, slot_y_bus;
    logic [4*N-1:0]  slot_id_bus;
    logic [2*N-1:0]  slot_or_bus;
    logic [3:0]      rom_sprite_id;
    logic [2:0]      rom_line_index;
    logic [1:0]      rom_orientation;
    logic [7:0]      rom_data;
    logic            pixel_on, fetch_busy;
    logic [SW-1:0]   pixel_slot;

    // Reference model state: what each slot's line buffer and column should be
    logic [7:0] mbuf[N];
    logic [9:0] mx  [N];
    int total = 0;
    int bad   = 0;

    always_comb begin
        for (int s = 0; s < N; s++) begin
            slot_x_bus[10*s +: 10] = sx[s];
            slot_y_bus[10*s +: 10] = sy[s];
            slot_id_bus[4*s +: 4]  = sid[s];
            slot_or_bus[2*s +: 2]  = sor[s];
        end
    end

    // Behavioural sprite ROM: real heart pattern, hashed content elsewhere.
    function automatic logic [7:0] rom_fn(input logic [3:0] id, input logic [2:0] ln,
                                          input logic [1:0] o);
        logic [7:0] v;
        if (id == HEART && o == UP) begin
            case (ln)
                3'd0: v = 8'hFF;
                3'd1: v = 8'h99;
                3'd2: v = 8'h00;
                3'd3: v = 8'h00;
                3'd4: v = 8'h81;
                3'd5: v = 8'hC3;
                3'd6: v = 8'hE7;
                default: v = 8'hFF;
            endcase
        end else begin
            v = 8'(int'(id) * 37 + int'(ln) * 11 + int'(o) * 89 + 5) ^ 8'h5A;
        end
        return v;
    endfunction

    assign rom_data = rom_fn(rom_sprite_id, rom_line_index, rom_orientation);

    sprite_line_fetcher #(.NUM_SLOTS(N), .SLOT_W(SW), .V_TOTAL(VT)) dut (
        .clk             (clk),
        .reset           (reset),
        .line_start      (line_start),
        .hpos            (hpos),
        .vpos            (vpos),
        .display_on      (display_on),
        .slot_valid      (slot_valid),
        .slot_x          (slot_x_bus),
        .slot_y          (slot_y_bus),
        .slot_id         (slot_id_bus),
        .slot_orient     (slot_or_bus),
        .rom_sprite_id   (rom_sprite_id),
        .rom_line_index  (rom_line_index),
        .rom_orientation (rom_orientation),
        .rom_data        (rom_data),
        .pixel_on        (pixel_on),
        .pixel_slot      (pixel_slot),
        .fetch_busy      (fetch_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int next_of(input int v);
        return (v == VT - 1) ? 0 : v + 1;
    endfunction

    // Model of one line fetch, from the slot table as it stands now
    task automatic model_fetch(input int v);
        int nl, d;
        nl = next_of(v);
        for (int s = 0; s < N; s++) begin
            d = nl - int'(sy[s]);
            if (slot_valid[s] && d >= 0 && d < 8) mbuf[s] = rom_fn(sid[s], 3'(d), sor[s]);
            else                                  mbuf[s] = 8'hFF;
            mx[s] = sx[s];
        end
    endtask

    // Pulse line_start at vpos v, then check each fetch cycle and the tail
    task automatic run_fetch(input int v);
        int nl;
        logic [2:0] el;
        vpos = 10'(v);
        model_fetch(v);
        nl = next_of(v);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        for (int s = 0; s < N; s++) begin
            el = 3'(nl - int'(sy[s]));
            total++;
            if ({fetch_busy, rom_sprite_id, rom_line_index, rom_orientation} !==
                {1'b1, sid[s], el, sor[s]}) begin
                bad++;
                $display("FAIL fetch_req slot%0d got busy=%b id=%0d idx=%0d or=%0d exp id=%0d idx=%0d or=%0d",
                         s, fetch_busy, rom_sprite_id, rom_line_index, rom_orientation, sid[s], el, sor[s]);
            end
            tick();
        end
        total++;
        if ({fetch_busy, rom_sprite_id, rom_line_index, rom_orientation} !== {1'b1, 9'd0}) begin
            bad++;
            $display("FAIL done_state got busy=%b rom=%h exp busy=1 rom=0", fetch_busy,
                     {rom_sprite_id, rom_line_index, rom_orientation});
        end
        tick();
        total++;
        if (fetch_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_fetch got busy=%b exp 0", fetch_busy);
        end
    endtask

    // Sweep hpos and compare against the model's priority pixel
    task automatic sweep(input int lo, input int hi, input bit rnd_disp);
        logic eon;
        logic [SW-1:0] es;
        int d;
        for (int h = lo; h <= hi; h++) begin
            hpos = 10'(h);
            display_on = rnd_disp ? ($urandom_range(0, 3) != 0) : 1'b1;
            eon = 1'b0;
            es  = '0;
            for (int s = 0; s < N; s++) begin
                d = h - int'(mx[s]);
                if (!eon && d >= 0 && d < 8 && mbuf[s][d] == 1'b0) begin
                    eon = 1'b1;
                    es  = SW'(s);
                end
            end
            eon = eon && display_on;
            tick();
            total++;
            if (pixel_on !== eon || (eon && pixel_slot !== es)) begin
                bad++;
                $display("FAIL pixel h=%0d got on=%b slot=%0d exp on=%b slot=%0d",
                         h, pixel_on, pixel_slot, eon, es);
            end
        end
        display_on = 1'b0;
    endtask

    task automatic clear_slots();
        slot_valid = '0;
        for (int s = 0; s < N; s++) begin
            sx[s] = 10'd0; sy[s] = 10'd0; sid[s] = 4'd0; sor[s] = UP;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({pixel_on, pixel_slot, fetch_busy, rom_sprite_id, rom_line_index, rom_orientation} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got on=%b slot=%0d busy=%b rom=%h exp all 0",
                     pixel_on, pixel_slot, fetch_busy, {rom_sprite_id, rom_line_index, rom_orientation});
        end
        reset = 1'b0;
        for (int s = 0; s < N; s++) begin mbuf[s] = 8'hFF; mx[s] = 10'd0; end
        sweep(0, 10, 1'b0);
    endtask

    task automatic test_heart();
        logic exp_on;
        clear_slots();
        slot_valid[0] = 1'b1; sx[0] = 10'd200; sy[0] = 10'd100; sid[0] = HEART; sor[0] = UP;
        run_fetch(100);
        vpos = 10'd101;
        for (int h = 198; h <= 209; h++) begin
            hpos = 10'(h);
            display_on = 1'b1;
            exp_on = (h == 201 || h == 202 || h == 205 || h == 206);
            tick();
            total++;
            if (pixel_on !== exp_on || (exp_on && pixel_slot !== 2'd0)) begin
                bad++;
                $display("FAIL heart_line1 h=%0d got on=%b slot=%0d exp on=%b slot=0",
                         h, pixel_on, pixel_slot, exp_on);
            end
        end
        display_on = 1'b0;
    endtask

    task automatic test_miss_below();
        run_fetch(107);
        vpos = 10'd108;
        sweep(190, 215, 1'b0);
    endtask

    task automatic test_overlap();
        clear_slots();
        slot_valid[1:0] = 2'b11;
        sx[0] = 10'd300; sy[0] = 10'd50; sid[0] = SWORD; sor[0] = UP;
        sx[1] = 10'd300; sy[1] = 10'd50; sid[1] = HEART; sor[1] = UP;
        run_fetch(50);
        sweep(296, 310, 1'b0);
    endtask

    task automatic test_wrap();
        clear_slots();
        slot_valid[0] = 1'b1; sx[0] = 10'd20; sy[0] = 10'd0; sid[0] = DRAGON_HEAD; sor[0] = LEFT;
        run_fetch(VT - 1);
        sweep(16, 30, 1'b0);
    endtask

    task automatic test_back_to_back();
        clear_slots();
        for (int s = 0; s < N; s++) begin
            slot_valid[s] = 1'b1; sx[s] = 10'(400 + 3 * s); sy[s] = 10'(200 + s);
            sid[s] = 4'(s + 4); sor[s] = 2'(s);
        end
        vpos = 10'd199;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        total++;
        if (fetch_busy !== 1'b1 || rom_sprite_id !== sid[1]) begin
            bad++;
            $display("FAIL restart_pre got busy=%b id=%0d exp busy=1 id=%0d", fetch_busy, rom_sprite_id, sid[1]);
        end
        run_fetch(203);
        sweep(396, 420, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        clear_slots();
        slot_valid[0] = 1'b1; sx[0] = 10'd200; sy[0] = 10'd100; sid[0] = HEART; sor[0] = UP;
        run_fetch(100);
        vpos = 10'd100;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({fetch_busy, pixel_on, rom_sprite_id, rom_line_index, rom_orientation} !== '0) begin
            bad++;
            $display("FAIL reset_mid_fetch got busy=%b on=%b rom=%h exp all 0", fetch_busy, pixel_on,
                     {rom_sprite_id, rom_line_index, rom_orientation});
        end
        for (int s = 0; s < N; s++) mbuf[s] = 8'hFF;
        sweep(195, 215, 1'b0);
    endtask

    task automatic test_random();
        int v, nl;
        for (int it = 0; it < 20; it++) begin
            v  = $urandom_range(0, VT - 1);
            nl = next_of(v);
            for (int s = 0; s < N; s++) begin
                slot_valid[s] = ($urandom_range(0, 4) != 0);
                sx[s]  = 10'($urandom_range(100, 115));
                sy[s]  = 10'((nl >= 9) ? nl - $urandom_range(0, 9) : nl);
                sid[s] = 4'($urandom_range(0, 8));
                sor[s] = 2'($urandom_range(0, 3));
            end
            run_fetch(v);
            // Table changes after the fetch must not disturb this line
            for (int s = 0; s < N; s++) begin
                slot_valid[s] = $urandom_range(0, 1) != 0;
                sx[s] = 10'($urandom_range(0, 1023));
                sy[s] = 10'($urandom_range(0, 1023));
                sid[s] = 4'($urandom_range(0, 15));
            end
            sweep(95, 126, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; display_on = 1'b0;
        hpos = '0; vpos = '0;
        clear_slots();
        test_reset();
        test_heart();
        test_miss_below();
        test_overlap();
        test_wrap();
        test_back_to_back();
        test_reset_mid_fetch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
- Reader/consumer side of the sprite ROM interface: during each horizontal blank, walks a table of NUM_SLOTS on-screen entities and issues (sprite_ID, line_index, orientation) requests to the sprite ROM.
- Captures each returned 8-pixel line into a per-slot line buffer, then serialises those buffers against hpos during the next active line as a pixel-on flag plus winning slot index.
- Sits between the entity/game-state logic, the VGA sync generator and the sprite ROM.

Parameters:
- NUM_SLOTS, 4, number of sprite slots fetched per line.
- SLOT_W, 2, width of slot index, equal to clog2(NUM_SLOTS).
- V_TOTAL, 525, total lines per frame, used for next-line wrap.

Ports:
- clk  in  1  system clock (pixel clock).
- reset  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse at the end of active video of each line (start of hblank).
- hpos  in  10  current horizontal pixel position.
- vpos  in  10  current line number, 0..V_TOTAL-1.
- display_on  in  1  high during the active region.
- slot_valid  in  NUM_SLOTS  per-slot enable.
- slot_x  in  10*NUM_SLOTS  per-slot left column in pixels; slot i occupies bits [10i+9:10i].
- slot_y  in  10*NUM_SLOTS  per-slot top line; packed the same way as slot_x.
- slot_id  in  4*NUM_SLOTS  per-slot sprite ID.
- slot_orient  in  2*NUM_SLOTS  per-slot orientation: 0 = UP, 1 = RIGHT, 2 = DOWN, 3 = LEFT.
- rom_sprite_id  out  4  request to the ROM.
- rom_line_index  out  3  request to the ROM.
- rom_orientation  out  2  request to the ROM.
- rom_data  in  8  combinational ROM response. Bit k is column k from the left. Active low: 0 = pixel on.
- pixel_on  out  1  a sprite pixel is lit at the previous cycle's hpos.
- pixel_slot  out  SLOT_W  index of the lit slot; valid only when pixel_on is high.
- fetch_busy  out  1  high while the fetch FSM is not IDLE.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - FSM goes to IDLE.
  - All line buffers are set to 8'hFF (all pixels off).
  - pixel_on, pixel_slot, fetch_busy, rom_sprite_id, rom_line_index and rom_orientation all go to 0.
- next_line = (vpos == V_TOTAL-1) ? 0 : vpos+1.
- FSM states: IDLE, FETCH, DONE.
  - IDLE -> FETCH on line_start. The slot counter is set to 0 and next_line is latched.
  - FETCH, one slot per cycle, for slot s = counter:
    - Drive rom_sprite_id = slot_id[s], rom_orientation = slot_orient[s], rom_line_index = dy[2:0].
    - dy = next_line - slot_y[s], computed 11 bits wide.
    - hit = slot_valid[s] AND next_line >= slot_y[s] AND dy < 8.
    - On the clock edge: buffer[s] <= hit ? rom_data : 8'hFF; counter increments.
    - After slot NUM_SLOTS-1 the FSM goes to DONE.
  - DONE -> IDLE on the next cycle.
  - Fetch length is NUM_SLOTS+1 cycles from line_start. fetch_busy is high in FETCH and DONE.
- ROM request outputs are driven combinationally from the counter in FETCH and held at 0 in IDLE and DONE. The ROM is combinational, so rom_data is sampled on the same edge.
- A line_start arriving while in FETCH or DONE restarts FETCH at slot 0 with a freshly latched next_line. Partially written buffers are overwritten.
- Slot inputs are sampled only while their slot is being fetched. Changes at any other time have no effect until the next line.
- Pixel path (registered, 1-cycle latency):
  - For each slot: dx = hpos - slot_x[s], 11 bits wide.
  - inside = hpos >= slot_x[s] AND dx < 8.
  - lit_s = inside AND buffer[s][dx[2:0]] == 0.
  - Next cycle: pixel_on <= display_on AND any lit_s; pixel_slot <= lowest-index lit slot, else 0.
  - Priority is fixed, lowest index wins, so slot 0 is drawn on top.
- Sprites with slot_x > 632 are clipped naturally because hpos never reaches those columns. Compare in 11 bits so slot_x+7 cannot wrap.
- Wrap: a fetch triggered on vpos = V_TOTAL-1 fetches line 0. A sprite with slot_y = 0 appears on line 0.
- The buffers hold their contents until the next fetch. Pixels are output only while display_on is high.

Decomposition:
- Shared package holds:
  - Orientation constants UP/RIGHT/DOWN/LEFT (also used by the ROM).
  - SPRITE_W = 8.
  - Sprite ID constants: HEART = 0, SWORD = 1, GNOME_IDLE_1/2 = 2/3, DRAGON_WING_UP/DOWN = 4/5, DRAGON_HEAD = 6, SHEEP_IDLE_1/2 = 7/8.
  - FSM state encoding.
- One natural sub-module: sprite_pixel_select. It takes the buffers, hpos, slot_x and display_on and produces the registered pixel_on/pixel_slot priority mux. The top level keeps the FSM and buffers.

Test Plan:
1. Slot0 valid, heart (ID 0, UP), x = 200, y = 100; line_start at vpos = 100 with the real ROM attached -> rom_line_index = 1 during FETCH; at vpos = 101 pixel_on is high the cycle after hpos = 201, 202, 205, 206 and low for all other hpos in 198..209; pixel_slot = 0.
2. Same setup with the line_start at vpos = 107 (fetches line 108) -> no hit, buffer = 8'hFF, pixel_on stays 0 for the whole line 108.
3. Slot0 sword at x = 300, slot1 heart at x = 300, both y = 50, vpos = 50 line -> overlapping lit columns report pixel_slot = 0; columns lit only by the heart report pixel_slot = 1.
4. slot_y = 0, line_start at vpos = 524 -> next_line = 0, rom_line_index = 0, buffer captured.
5. line_start pulsed again on the 2nd FETCH cycle -> counter restarts at 0, fetch_busy stays high, DONE is reached NUM_SLOTS+1 cycles after the second pulse.
6. reset asserted mid-FETCH -> next cycle: IDLE, fetch_busy = 0, all buffers = 8'hFF, pixel_on = 0.
